// File: rtl/onehot_decoder.sv
// Binary-index to one-hot decoder behind a two-entry output buffer (main + skid)
// with a registered in_ready and accept-time decode/error counters.
module onehot_decoder #(
    parameter  int DATA_WIDTH = 8,
    localparam int POS_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [POS_W-1:0]      in_pos,
    input  logic                  in_nz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    input  logic                  clr_cnt,
    output logic [15:0]           dec_cnt,
    output logic [7:0]            err_cnt,
    output logic [1:0]            dbg_state
);

    // Handshake: a word moves only in a cycle where valid && ready are both high
    // at the rising edge; in_ready depends on registered state only, never on out_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_err;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_err;
    logic [15:0]           r_dec_cnt;
    logic [7:0]            r_err_cnt;

    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_in_range;
    logic                  w_dec_err;
    logic [DATA_WIDTH-1:0] w_dec_data;
    logic                  w_load_main;
    logic                  w_load_skid;
    logic                  w_skid_to_main;

    assign w_accept   = in_valid && r_in_ready;
    assign w_xfer     = out_valid && out_ready;
    assign w_in_range = ({1'b0, in_pos} < (POS_W+1)'(DATA_WIDTH));
    assign w_dec_err  = in_nz && !w_in_range;

    // Out-of-range indices match no bit, so the word is all-zero by construction.
    always_comb begin
        w_dec_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (in_nz && (in_pos == POS_W'(i))) begin
                w_dec_data[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_xfer) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_xfer) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main) begin
                r_main_data <= w_dec_data;
                r_main_err  <= w_dec_err;
            end else if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_dec_data;
                r_skid_err  <= w_dec_err;
            end
        end
    end

    // Counters follow accepts, so they can run ahead of the words still buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_dec_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept && in_nz && w_in_range) begin
                r_dec_cnt <= r_dec_cnt + 16'd1;
            end
            if (w_accept && w_dec_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_data;
    assign out_err   = r_main_err;
    assign dec_cnt   = r_dec_cnt;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: an 8-bit instance for the data path, buffering,
// reset and clear, and a 6-bit instance for out-of-range and saturation behaviour.
module tb_onehot_decoder;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_in_nz, a_out_valid, a_out_ready, a_out_err, a_clr;
    logic [2:0]  a_in_pos;
    logic [7:0]  a_out_data;
    logic [15:0] a_dec_cnt;
    logic [7:0]  a_err_cnt;
    logic [1:0]  a_state;

    logic        b_in_valid, b_in_ready, b_in_nz, b_out_valid, b_out_ready, b_out_err, b_clr;
    logic [2:0]  b_in_pos;
    logic [5:0]  b_out_data;
    logic [15:0] b_dec_cnt;
    logic [7:0]  b_err_cnt;
    logic [1:0]  b_state;

    int n_checks;
    int n_fail;

    onehot_decoder #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pos(a_in_pos), .in_nz(a_in_nz),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
        .clr_cnt(a_clr), .dec_cnt(a_dec_cnt), .err_cnt(a_err_cnt), .dbg_state(a_state)
    );

    onehot_decoder #(.DATA_WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pos(b_in_pos), .in_nz(b_in_nz),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
        .clr_cnt(b_clr), .dec_cnt(b_dec_cnt), .err_cnt(b_err_cnt), .dbg_state(b_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers: inputs change on the falling edge, outputs are checked #1 after the rising edge.
    task automatic step8(input logic v, input logic [2:0] pos, input logic nz, input logic ordy, input logic clr);
        @(negedge clk);
        a_in_valid  = v;
        a_in_pos    = pos;
        a_in_nz     = nz;
        a_out_ready = ordy;
        a_clr       = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step6(input logic v, input logic [2:0] pos, input logic nz);
        @(negedge clk);
        b_in_valid  = v;
        b_in_pos    = pos;
        b_in_nz     = nz;
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", a_out_data); end
        n_checks++; if (a_out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", a_out_err); end
        n_checks++; if (a_dec_cnt !== 16'd0 || a_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", a_dec_cnt, a_err_cnt); end
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", a_state); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_data;
        for (int p = 0; p < 8; p++) begin
            step8(1'b1, 3'(p), 1'b1, 1'b1, 1'b0);
            exp_data = 8'h01 << p;
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_data || a_out_err !== 1'b0) begin
                n_fail++; $display("FAIL sweep_pos%0d: got v=%b d=%h e=%b want v=1 d=%h e=0", p, a_out_valid, a_out_data, a_out_err, exp_data);
            end
            n_checks++; if ($countones(a_out_data) != 1) begin n_fail++; $display("FAIL sweep_popcount%0d: got %0d want 1", p, $countones(a_out_data)); end
        end
        step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain: out_valid got %b want 0", a_out_valid); end
        n_checks++; if (a_dec_cnt !== 16'd8) begin n_fail++; $display("FAIL sweep_dec_cnt: got %0d want 8", a_dec_cnt); end
    endtask

    task automatic test_zero();
        step8(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h00 || a_out_err !== 1'b0) begin
            n_fail++; $display("FAIL zero_word: got v=%b d=%h e=%b want v=1 d=00 e=0", a_out_valid, a_out_data, a_out_err);
        end
        n_checks++; if (a_dec_cnt !== 16'd8 || a_err_cnt !== 8'd0) begin n_fail++; $display("FAIL zero_counters: got %0d/%0d want 8/0", a_dec_cnt, a_err_cnt); end
        step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_out_of_range();
        step6(1'b1, 3'd6, 1'b1);
        n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 6'h00 || b_out_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_pos6: got v=%b d=%h e=%b want v=1 d=00 e=1", b_out_valid, b_out_data, b_out_err);
        end
        n_checks++; if (b_err_cnt !== 8'd1) begin n_fail++; $display("FAIL oor_err_cnt1: got %0d want 1", b_err_cnt); end
        step6(1'b1, 3'd7, 1'b1);
        n_checks++; if (b_out_data !== 6'h00 || b_out_err !== 1'b1) begin n_fail++; $display("FAIL oor_pos7: got d=%h e=%b want d=00 e=1", b_out_data, b_out_err); end
        n_checks++; if (b_err_cnt !== 8'd2) begin n_fail++; $display("FAIL oor_err_cnt2: got %0d want 2", b_err_cnt); end
        for (int i = 0; i < 298; i++) begin
            step6(1'b1, (i % 2 == 0) ? 3'd6 : 3'd7, 1'b1);
        end
        n_checks++; if (b_err_cnt !== 8'd255) begin n_fail++; $display("FAIL oor_saturate: got %0d want 255", b_err_cnt); end
        n_checks++; if (b_dec_cnt !== 16'd0) begin n_fail++; $display("FAIL oor_dec_cnt: got %0d want 0", b_dec_cnt); end
        step6(1'b1, 3'd5, 1'b1);
        n_checks++; if (b_out_data !== 6'h20 || b_out_err !== 1'b0 || b_dec_cnt !== 16'd1 || b_err_cnt !== 8'd255) begin
            n_fail++; $display("FAIL w6_top_bit: got d=%h e=%b dec=%0d err=%0d want d=20 e=0 dec=1 err=255", b_out_data, b_out_err, b_dec_cnt, b_err_cnt);
        end
        step6(1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step8(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (a_out_data !== 8'h02 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got d=%h rdy=%b want d=02 rdy=1", a_out_data, a_in_ready); end
        step8(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b0 || a_out_data !== 8'h02 || a_state !== 2'd2) begin
            n_fail++; $display("FAIL b2b_full: got rdy=%b d=%h st=%0d want rdy=0 d=02 st=2", a_in_ready, a_out_data, a_state);
        end
        step8(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        n_checks++; if (a_in_ready !== 1'b0 || a_out_data !== 8'h02 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_hold: got rdy=%b d=%h v=%b want rdy=0 d=02 v=1", a_in_ready, a_out_data, a_out_valid);
        end
        step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (a_out_data !== 8'h04 || a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got d=%h rdy=%b v=%b want d=04 rdy=1 v=1", a_out_data, a_in_ready, a_out_valid);
        end
        step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", a_out_valid); end
        n_checks++; if (a_dec_cnt !== 16'd10) begin n_fail++; $display("FAIL b2b_dec_cnt: got %0d want 10", a_dec_cnt); end
    endtask

    task automatic test_reset_in_two();
        step8(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        step8(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        step8(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (a_state !== 2'd2 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst2_fill: got st=%0d rdy=%b want st=2 rdy=0", a_state, a_in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst2_flags: got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready); end
        n_checks++; if (a_dec_cnt !== 16'd0 || a_err_cnt !== 8'd0 || b_err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rst2_counters: got %0d/%0d/%0d want 0/0/0", a_dec_cnt, a_err_cnt, b_err_cnt);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
            n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00) begin
                n_fail++; $display("FAIL rst2_no_replay%0d: got v=%b d=%h want v=0 d=00", i, a_out_valid, a_out_data);
            end
        end
    endtask

    task automatic test_clr();
        step8(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (a_dec_cnt !== 16'd1 || a_out_data !== 8'h01) begin n_fail++; $display("FAIL clr_pre: got dec=%0d d=%h want dec=1 d=01", a_dec_cnt, a_out_data); end
        step8(1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
        n_checks++; if (a_dec_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got dec=%0d want 0", a_dec_cnt); end
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h20) begin n_fail++; $display("FAIL clr_datapath: got v=%b d=%h want v=1 d=20", a_out_valid, a_out_data); end
        step8(1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
        n_checks++; if (a_dec_cnt !== 16'd1 || a_out_data !== 8'h40) begin n_fail++; $display("FAIL clr_after: got dec=%0d d=%h want dec=1 d=40", a_dec_cnt, a_out_data); end
        step8(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        a_in_valid = 1'b0; a_in_pos = 3'd0; a_in_nz = 1'b0; a_out_ready = 1'b1; a_clr = 1'b0;
        b_in_valid = 1'b0; b_in_pos = 3'd0; b_in_nz = 1'b0; b_out_ready = 1'b1; b_clr = 1'b0;
        test_reset();
        test_sweep();
        test_zero();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_two();
        test_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the decoded one-hot word (minimum 2).
REQ-002 The block SHALL have localparam POS_W = $clog2(DATA_WIDTH), giving the width of the binary index input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input index is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an input this cycle.
REQ-007 The block SHALL have port in_pos, input, POS_W bits: binary bit index to decode.
REQ-008 The block SHALL have port in_nz, input, 1 bit: index is meaningful; 0 means "no bit set".
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data/out_err hold a decoded word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the word this cycle.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: decoded one-hot (or all-zero) word.
REQ-012 The block SHALL have port out_err, output, 1 bit: in_pos was out of range (in_pos >= DATA_WIDTH with in_nz=1).
REQ-013 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of both counters.
REQ-014 The block SHALL have port dec_cnt, output, 16 bits: count of accepted valid one-hot decodes, wrapping.
REQ-015 The block SHALL have port err_cnt, output, 8 bits: count of accepted out-of-range indices, saturating.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; transfer SHALL occur when out_valid && out_ready.
REQ-017 Decode SHALL be: in_nz=1 and in_pos<DATA_WIDTH -> out_data = 1<<in_pos, out_err=0.
REQ-018 Decode SHALL be: in_nz=0 -> out_data=0, out_err=0.
REQ-019 Decode SHALL be: in_nz=1 and in_pos>=DATA_WIDTH -> out_data=0, out_err=1.
REQ-020 Every out_data word SHALL be either all-zero or have exactly one bit set.
REQ-021 Output SHALL come from a main register plus one skid register; FSM states are EMPTY, ONE and TWO.
REQ-022 EMPTY SHALL go to ONE on accept (main loaded).
REQ-023 ONE SHALL go to TWO on accept without transfer (skid loaded); stay ONE on accept with transfer (main reloaded); go to EMPTY on transfer only.
REQ-024 TWO SHALL accept nothing and go to ONE on transfer (skid moves into main).
REQ-025 in_ready SHALL be a registered output, equal to 1 in EMPTY and ONE and 0 in TWO; there is no combinational path from out_ready to in_ready.
REQ-026 out_valid SHALL be 1 in ONE and TWO.
REQ-027 Latency SHALL be 1 cycle: a word accepted at edge N is visible on out_data after edge N when the main register is free.
REQ-028 Throughput SHALL be 1 word per cycle while out_ready=1.
REQ-029 Words SHALL leave in acceptance order; none is dropped or duplicated.
REQ-030 While out_valid=1 and out_ready=0, out_data and out_err SHALL be held stable.
REQ-031 dec_cnt SHALL increment by 1 on each accept with in_nz=1 and in-range index, wrapping 0xFFFF->0.
REQ-032 err_cnt SHALL increment on each accept with out_err condition and hold at 255.
REQ-033 Counters SHALL update at accept, not at transfer.
REQ-034 clr_cnt=1 SHALL zero both counters on the next edge; clr_cnt SHALL win over a simultaneous increment.
REQ-035 clr_cnt SHALL NOT affect the data path or the FSM.

Reset
REQ-036 rst_n=0 SHALL immediately force: FSM=EMPTY, in_ready=1, out_valid=0, out_data=0, out_err=0, skid register=0, dec_cnt=0, err_cnt=0.
REQ-037 Reset mid-operation (ONE or TWO) SHALL discard held words without emitting them.
REQ-038 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-039 The bench SHALL check, for DATA_WIDTH=8 with out_ready=1: sweep in_pos 0..7 with in_nz=1 -> out_data 0x01,0x02,...,0x80 on consecutive cycles, each popcount 1, dec_cnt=8.
REQ-040 The bench SHALL check: in_nz=0, in_pos=3 -> out_data=0x00, out_err=0, counters unchanged.
REQ-041 The bench SHALL check, for DATA_WIDTH=6: in_pos=6 or 7 with in_nz=1 -> out_data=0, out_err=1, err_cnt increments; 300 such accepts -> err_cnt=255.
REQ-042 The bench SHALL check: out_ready=0, accept pos 1 then pos 2 -> in_ready=0 after second accept, out_data=0x02 held; then out_ready=1 -> 0x02 then 0x04 on consecutive cycles, in_ready returns to 1.
REQ-043 The bench SHALL check: rst_n pulsed low while in TWO -> out_valid=0, in_ready=1, counters=0 immediately, and neither held word appears afterward.
REQ-044 The bench SHALL check: clr_cnt=1 in the same cycle as a valid accept -> dec_cnt=0 next cycle, while the word is still emitted normally.
